// File: rtl/pulse_generator_pkg.sv
// Shared definitions for the pulse generator.
//   state_e      : FSM state encoding (IDLE=0, ACTIVE=1, HOLDOFF=2)
//   EDGE_*       : {previous, current} sample patterns for edge detection
//   cnt_width()  : counter width able to hold max(WIDTH,GAP)-1
`ifndef PULSE_GENERATOR_PKG_SV
`define PULSE_GENERATOR_PKG_SV

package pulse_generator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_e;

  // Edge-detect patterns, written as {previous, current}.
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;

  // The counter is loaded with (length - 1) and counts down to zero, so it
  // only has to hold max(WIDTH,GAP)-1. Never narrower than one bit.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

`endif

// File: rtl/pulse_generator_load_down_counter.sv
// Loadable down-counter with zero detect.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears the count
//   load     : load load_val this edge (wins over dec)
//   load_val : value to load
//   dec      : decrement this edge; saturates at zero
//   zero     : count is zero (straight from the count flops)
module load_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every variable written in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering in simulation.
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_generator.sv
// Tick-triggered fixed-length pulse generator with holdoff.
//   clk     : single clock, rising edge
//   reset   : synchronous active-high reset
//   tick    : single-cycle request, sampled every edge
//   out     : registered pulse, MODE level while active, ~MODE otherwise
//   busy    : registered, high during ACTIVE and HOLDOFF
//   dropped : registered one-cycle flag for a rejected tick
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int MODE   = 1,
  parameter int WIDTH  = 4,
  parameter int GAP    = 2,
  parameter int RETRIG = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  output logic out,
  output logic busy,
  output logic dropped
);

  generate
    if ((WIDTH < 1) || (WIDTH > 255)) begin : g_bad_width
      $error("pulse_generator: WIDTH must be in 1..255");
    end
    if ((GAP < 0) || (GAP > 255)) begin : g_bad_gap
      $error("pulse_generator: GAP must be in 0..255");
    end
    if ((MODE != 0) && (MODE != 1)) begin : g_bad_mode
      $error("pulse_generator: MODE must be 0 or 1");
    end
    if ((RETRIG != 0) && (RETRIG != 1)) begin : g_bad_retrig
      $error("pulse_generator: RETRIG must be 0 or 1");
    end
  endgenerate

  localparam int               CNT_W  = cnt_width(WIDTH, GAP);
  localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(WIDTH - 1);
  // Only used when GAP > 0, so the GAP = 0 wrap is harmless.
  localparam logic [CNT_W-1:0] G_LOAD = CNT_W'(GAP - 1);
  localparam logic             ON_LVL = (MODE != 0);

  state_e           state_q, state_d;
  logic             out_q, out_d;
  logic             busy_q, busy_d;
  logic             dropped_q, dropped_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;

  load_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    dropped_d    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = W_LOAD;
    cnt_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = ACTIVE;
          cnt_load = 1'b1;
        end
      end

      ACTIVE: begin
        if (tick && (RETRIG != 0)) begin
          // Restart the full pulse length from this tick.
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          if (GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d      = HOLDOFF;
            cnt_load     = 1'b1;
            cnt_load_val = G_LOAD;
          end
          // With no holdoff, a tick on the closing cycle falls on the edge
          // that ends the pulse and is absorbed silently; the very next
          // cycle is already idle and accepts ticks normally.
          dropped_d = tick && (GAP != 0);
        end else begin
          cnt_dec   = 1'b1;
          dropped_d = tick;
        end
      end

      HOLDOFF: begin
        dropped_d = tick;
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so they come straight from flops with
    // the one-cycle latency from tick.
    out_d  = (state_d == ACTIVE) ? ON_LVL : ~ON_LVL;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= ~ON_LVL;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      busy_q    <= busy_d;
      dropped_q <= dropped_d;
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: three configurations driven with the same
// directed tick/reset tables, each compared every cycle against a
// cycle-number model, plus literal expectations for the configuration each
// scenario targets.
//   dut 0 : MODE=1 WIDTH=4 GAP=2 RETRIG=0
//   dut 1 : MODE=1 WIDTH=4 GAP=2 RETRIG=1
//   dut 2 : MODE=0 WIDTH=4 GAP=0 RETRIG=0
module tb_pulse_generator;

  localparam int W      = 4;
  localparam int N_SCN  = 6;
  localparam int SCN_LEN = 35;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic tick;
  logic out0, busy0, drop0;
  logic out1, busy1, drop1;
  logic out2, busy2, drop2;
  logic [2:0] out_v, busy_v, drop_v;

  assign out_v  = {out2, out1, out0};
  assign busy_v = {busy2, busy1, busy0};
  assign drop_v = {drop2, drop1, drop0};

  pulse_generator #(.MODE(1), .WIDTH(W), .GAP(2), .RETRIG(0)) u_dut0 (
    .clk(clk), .reset(reset), .tick(tick), .out(out0), .busy(busy0), .dropped(drop0)
  );
  pulse_generator #(.MODE(1), .WIDTH(W), .GAP(2), .RETRIG(1)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick), .out(out1), .busy(busy1), .dropped(drop1)
  );
  pulse_generator #(.MODE(0), .WIDTH(W), .GAP(0), .RETRIG(0)) u_dut2 (
    .clk(clk), .reset(reset), .tick(tick), .out(out2), .busy(busy2), .dropped(drop2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  function automatic int p_mode(input int i);   return (i == 2) ? 0 : 1; endfunction
  function automatic int p_gap(input int i);    return (i == 2) ? 0 : 2; endfunction
  function automatic bit p_retrig(input int i); return (i == 1);         endfunction

  function automatic bit in_r(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Stimulus tables, in scenario-local cycle numbers.
  function automatic bit tick_at(input int s, input int c);
    case (s)
      0: return in_r(c, 10, 12);
      1: return (c == 10) || (c == 17);
      2: return (c == 10) || (c == 12) || (c == 15);
      3: return (c == 10) || (c == 12);
      4: return in_r(c, 10, 20);
      5: return (c == 10) || (c == 13);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit rst_at(input int s, input int c);
    return (c <= 1) || ((s == 0) && in_r(c, 10, 12)) || ((s == 5) && (c == 12));
  endfunction

  // Which configuration each scenario's hand-computed table describes.
  function automatic int dsel(input int s);
    return (s == 3) ? 1 : ((s == 4) ? 2 : 0);
  endfunction

  // Hand-computed expectations for the targeted configuration.
  function automatic void lit(input int s, input int c,
                              output logic o, output logic b, output logic d);
    o = 1'b0; b = 1'b0; d = 1'b0;
    case (s)
      1: begin
        o = in_r(c, 11, 14) || in_r(c, 18, 21);
        b = in_r(c, 11, 16) || in_r(c, 18, 23);
      end
      2: begin
        o = in_r(c, 11, 14);
        b = in_r(c, 11, 16);
        d = (c == 13) || (c == 16);
      end
      3: begin
        o = in_r(c, 11, 16);
        b = in_r(c, 11, 18);
      end
      4: begin
        b = in_r(c, 11, 14) || in_r(c, 16, 19) || in_r(c, 21, 24);
        o = ~b;
        d = in_r(c, 12, 14) || in_r(c, 17, 19);
      end
      5: begin
        o = in_r(c, 11, 12) || in_r(c, 14, 17);
        b = in_r(c, 11, 12) || in_r(c, 14, 19);
      end
      default: ;
    endcase
  endfunction

  // Model: per configuration, the last cycle the pulse is on, the first
  // cycle that is idle again, and whether the next cycle shows a drop.
  int active_until[3];
  int idle_from[3];
  bit drop_next[3];
  bit valid;

  initial begin
    int g;
    logic e_out, e_busy, e_drop, l_out, l_busy, l_drop;
    reset = 1'b1;
    tick  = 1'b0;
    valid = 1'b0;
    g     = 0;
    for (int i = 0; i < 3; i++) begin
      active_until[i] = -100;
      idle_from[i]    = 0;
      drop_next[i]    = 1'b0;
    end

    for (int s = 0; s < N_SCN; s++) begin
      for (int c = 0; c < SCN_LEN; c++) begin
        @(negedge clk);
        if (valid) begin
          for (int i = 0; i < 3; i++) begin
            e_out  = (g <= active_until[i]) ? logic'(p_mode(i)) : ~logic'(p_mode(i));
            e_busy = (g < idle_from[i]);
            e_drop = drop_next[i];
            check($sformatf("s%0d c%0d dut%0d out", s, c, i), out_v[i], e_out);
            check($sformatf("s%0d c%0d dut%0d busy", s, c, i), busy_v[i], e_busy);
            check($sformatf("s%0d c%0d dut%0d dropped", s, c, i), drop_v[i], e_drop);
          end
          if (c >= 2) begin
            lit(s, c, l_out, l_busy, l_drop);
            check($sformatf("lit s%0d c%0d out", s, c), out_v[dsel(s)], l_out);
            check($sformatf("lit s%0d c%0d busy", s, c), busy_v[dsel(s)], l_busy);
            check($sformatf("lit s%0d c%0d dropped", s, c), drop_v[dsel(s)], l_drop);
          end
        end

        tick  = tick_at(s, c);
        reset = rst_at(s, c);

        for (int i = 0; i < 3; i++) begin
          drop_next[i] = 1'b0;
          if (reset) begin
            active_until[i] = -100;
            idle_from[i]    = g + 1;
          end else if (tick) begin
            if (g >= idle_from[i]) begin
              active_until[i] = g + W;
              idle_from[i]    = g + W + p_gap(i) + 1;
            end else if ((g <= active_until[i]) && p_retrig(i)) begin
              active_until[i] = g + W;
              idle_from[i]    = g + W + p_gap(i) + 1;
            end else if ((g == active_until[i]) && (p_gap(i) == 0)) begin
              // closing cycle of a zero-gap pulse: neither taken nor flagged
            end else begin
              drop_next[i] = 1'b1;
            end
          end
        end
        if (reset) valid = 1'b1;
        g++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
PULSE_GENERATOR -- requirements
Module: pulse_generator

Interface
REQ-001 SHALL have parameter MODE, default 1, output polarity: 1 = active-high pulse, 0 = active-low pulse.
REQ-002 SHALL have parameter WIDTH, default 4, pulse length in clk cycles, legal range 1..255.
REQ-003 SHALL have parameter GAP, default 2, minimum idle cycles after a pulse before the next tick is accepted, legal range 0..255.
REQ-004 SHALL have parameter RETRIG, default 0, where 1 lets a tick during a pulse extend that pulse.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port tick  input  1  single-cycle request, sampled every rising clk edge.
REQ-008 SHALL have port out  output  1  registered pulse output, polarity per MODE.
REQ-009 SHALL have port busy  output  1  high while a pulse or holdoff is in progress.
REQ-010 SHALL have port dropped  output  1  one-cycle flag for a rejected tick.

Function
REQ-011 SHALL implement the states IDLE, ACTIVE and HOLDOFF with a down-counter sized for max(WIDTH,GAP).
REQ-012 SHALL, while in IDLE, drive out = ~MODE and busy = 0.
REQ-013 SHALL, on a tick in IDLE in cycle N, drive out = MODE in cycles N+1..N+WIDTH, which is one cycle of latency.
REQ-014 SHALL, after ACTIVE, enter HOLDOFF for cycles N+WIDTH+1..N+WIDTH+GAP with out = ~MODE, then return to IDLE.
REQ-015 SHALL, when GAP = 0, go from ACTIVE directly to IDLE, so a tick in cycle N+WIDTH+1 is accepted.
REQ-016 SHALL hold busy = 1 in every ACTIVE and HOLDOFF cycle and nowhere else.
REQ-017 SHALL, when RETRIG = 1 and a tick occurs in ACTIVE in cycle M, reload the counter so that out stays at MODE through cycle M+WIDTH.
REQ-018 SHALL, when RETRIG = 0 and a tick occurs in ACTIVE, ignore the tick and raise dropped in cycle M+1 for exactly one cycle.
REQ-019 SHALL, on any tick in HOLDOFF (including the last holdoff cycle), ignore the tick and raise dropped in cycle M+1 for one cycle.
REQ-020 SHALL, on consecutive rejected ticks, raise dropped in each corresponding next cycle, so dropped never coalesces.
REQ-021 SHALL treat a tick held high for several cycles as one tick per cycle, with each cycle evaluated independently per REQ-013..REQ-019.
REQ-022 SHALL never leave out at MODE for more than WIDTH consecutive cycles when RETRIG = 0.
REQ-023 SHALL register out, busy and dropped directly from flops, with no combinational path from tick.
REQ-024 SHALL produce an elaboration error if WIDTH < 1, WIDTH > 255 or GAP > 255.

Reset
REQ-025 SHALL, when reset is high at a rising edge, force state = IDLE, counter = 0, out = ~MODE, busy = 0 and dropped = 0 at that edge.
REQ-026 SHALL give reset priority over tick in the same cycle, so the tick is discarded and dropped is not raised.
REQ-027 SHALL, on reset mid-pulse or mid-holdoff, abort immediately with no residual pulse, and accept a tick in the first cycle after reset deasserts.

Structure
REQ-028 SHALL take the state encodings IDLE=0, ACTIVE=1, HOLDOFF=2 from the shared guarded include header, alongside the edge-detect constants.
REQ-029 SHALL place the counter load/decrement/zero-detect logic in one sub-module, load_down_counter, parameterised by width.
REQ-030 SHALL keep the FSM and output registers in pulse_generator itself.

Verification
REQ-031 SHALL check the reset scenario: reset high for 3 cycles with tick high -> out=0, busy=0 and dropped=0 throughout and one cycle after (MODE=1).
REQ-032 SHALL check the basic pulse scenario: WIDTH=4, GAP=2, tick in cycle 10 -> out=1 in cycles 11-14, busy=1 in cycles 11-16, and a tick in cycle 17 is accepted with out=1 in cycles 18-21.
REQ-033 SHALL check the no-retrigger scenario: RETRIG=0, ticks in cycles 10, 12 and 15 -> out=1 in cycles 11-14 only, dropped=1 in cycles 13 and 16.
REQ-034 SHALL check the retrigger scenario: RETRIG=1, ticks in cycles 10 and 12 -> out=1 in cycles 11-16, busy=1 in cycles 11-18, dropped never high.
REQ-035 SHALL check the active-low, zero-gap scenario: MODE=0, GAP=0, tick held high in cycles 10-20 -> out=0 in cycles 11-14, 16-19 and 21-24, dropped=1 in cycles 12-14 and 17-19.
REQ-036 SHALL check the mid-pulse reset scenario: tick in cycle 10, reset in cycle 12 -> out=0 and busy=0 from cycle 13, and a tick in cycle 13 gives out=1 in cycles 14-17.
